// File: rtl/decode_if.sv
// Decode-stage bundle: fetch outputs, hazard controls, forwarding sources and D-stage results.
// master drives fetch/forwarding/hazard signals; slave is the decode stage itself.
interface decode_if;
  logic [2:0]  f_stat;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;
  logic        D_stall, D_bubble;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun;
  logic [63:0] D_valC;
  logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] d_valA, d_valB;

  modport master (
    output f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, D_stall, D_bubble,
           e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM, W_dstE, W_valE, W_dstM, W_valM,
    input  D_stat, D_icode, D_ifun, D_valC, d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB
  );
  modport slave (
    input  f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, D_stall, D_bubble,
           e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM, W_dstE, W_valE, W_dstM, W_valM,
    output D_stat, D_icode, D_ifun, D_valC, d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB
  );
endinterface

// File: rtl/decode_stage.sv
// Y86-64 decode: F/D pipeline register, 15-entry register file, register selection and forwarding.
// f_* -> D_* one cycle; D_* -> d_* combinational. Stall holds D, bubble loads a nop.
module decode_stage (
  input  logic     clk,
  input  logic     reset,
  decode_if.slave  dif
);
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;
  localparam int         NREG  = 15;

  logic [2:0]  stat_q, stat_d;
  logic [3:0]  icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
  logic [63:0] valc_q, valc_d, valp_q, valp_d;
  logic [63:0] regs_q [NREG];

  always_comb begin
    stat_d  = stat_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    if (!dif.D_stall) begin
      if (dif.D_bubble) begin
        stat_d  = 3'd1;
        icode_d = 4'h1;
        ifun_d  = 4'h0;
        ra_d    = RNONE;
        rb_d    = RNONE;
        valc_d  = '0;
        valp_d  = '0;
      end else begin
        stat_d  = dif.f_stat;
        icode_d = dif.f_icode;
        ifun_d  = dif.f_ifun;
        ra_d    = dif.f_rA;
        rb_d    = dif.f_rB;
        valc_d  = dif.f_valC;
        valp_d  = dif.f_valP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_q  <= 3'd1;
      icode_q <= 4'h1;
      ifun_q  <= 4'h0;
      ra_q    <= RNONE;
      rb_q    <= RNONE;
      valc_q  <= '0;
      valp_q  <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      stat_q  <= stat_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      // M port is written last so it wins when both ports target the same register
      if (dif.W_dstE != RNONE) regs_q[dif.W_dstE] <= dif.W_valE;
      if (dif.W_dstM != RNONE) regs_q[dif.W_dstM] <= dif.W_valM;
    end
  end

  logic [3:0] src_a, src_b, dst_e, dst_m;

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode_q)
      4'h2: begin src_a = ra_q; dst_e = rb_q; end
      4'h3: dst_e = rb_q;
      4'h4: begin src_a = ra_q; src_b = rb_q; end
      4'h5: begin src_b = rb_q; dst_m = ra_q; end
      4'h6: begin src_a = ra_q; src_b = rb_q; dst_e = rb_q; end
      4'h8: begin src_b = RSP; dst_e = RSP; end
      4'h9: begin src_a = RSP; src_b = RSP; dst_e = RSP; end
      4'hA: begin src_a = ra_q; src_b = RSP; dst_e = RSP; end
      4'hB: begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = ra_q; end
      default: ;
    endcase
  end

  // Youngest producer first; W forwarding covers the register written on this same edge.
  function automatic logic [63:0] fwd(input logic [3:0] src, input logic [63:0] rf_val);
    if (src == RNONE)             return '0;
    else if (src == dif.e_dstE)   return dif.e_valE;
    else if (src == dif.M_dstM)   return dif.m_valM;
    else if (src == dif.M_dstE)   return dif.M_valE;
    else if (src == dif.W_dstM)   return dif.W_valM;
    else if (src == dif.W_dstE)   return dif.W_valE;
    else                          return rf_val;
  endfunction

  logic [63:0] rf_a, rf_b;
  always_comb begin
    rf_a = '0;
    rf_b = '0;
    if (src_a != RNONE) rf_a = regs_q[src_a];
    if (src_b != RNONE) rf_b = regs_q[src_b];
  end

  assign dif.d_valA  = (icode_q == 4'h7 || icode_q == 4'h8) ? valp_q : fwd(src_a, rf_a);
  assign dif.d_valB  = fwd(src_b, rf_b);
  assign dif.d_srcA  = src_a;
  assign dif.d_srcB  = src_b;
  assign dif.d_dstE  = dst_e;
  assign dif.d_dstM  = dst_m;
  assign dif.D_stat  = stat_q;
  assign dif.D_icode = icode_q;
  assign dif.D_ifun  = ifun_q;
  assign dif.D_valC  = valc_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: inputs change 1 ns after posedge, outputs sampled before next edge.
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  decode_if dif ();
  decode_stage dut (.clk(clk), .reset(reset), .dif(dif.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] valc, input logic [63:0] valp);
    dif.f_stat  = 3'd1;
    dif.f_icode = icode;
    dif.f_ifun  = 4'h0;
    dif.f_rA    = ra;
    dif.f_rB    = rb;
    dif.f_valC  = valc;
    dif.f_valP  = valp;
  endtask

  task automatic fwd_clear();
    dif.e_dstE = 4'hF; dif.e_valE = '0;
    dif.M_dstE = 4'hF; dif.M_valE = '0;
    dif.M_dstM = 4'hF; dif.m_valM = '0;
    dif.W_dstE = 4'hF; dif.W_valE = '0;
    dif.W_dstM = 4'hF; dif.W_valM = '0;
  endtask

  initial begin
    dif.D_stall = 1'b0;
    dif.D_bubble = 1'b0;
    fwd_clear();
    fetch(4'h6, 4'h2, 4'h3, 64'h99, 64'h77);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    // reset wins over a pending fetch
    chk("rst_icode", 64'(dif.D_icode), 64'h1);
    chk("rst_stat",  64'(dif.D_stat),  64'h1);
    chk("rst_srcA",  64'(dif.d_srcA),  64'hF);
    chk("rst_srcB",  64'(dif.d_srcB),  64'hF);
    chk("rst_dstE",  64'(dif.d_dstE),  64'hF);
    chk("rst_dstM",  64'(dif.d_dstM),  64'hF);
    chk("rst_valC",  dif.D_valC,       64'h0);

    // rrmovq %rbx,%rcx with regfile[3] written on the loading edge
    fetch(4'h2, 4'h3, 4'h1, 64'h0, 64'h2);
    dif.W_dstE = 4'h3; dif.W_valE = 64'h55;
    tick();
    fwd_clear();
    chk("rr_srcA", 64'(dif.d_srcA), 64'h3);
    chk("rr_dstE", 64'(dif.d_dstE), 64'h1);
    chk("rr_dstM", 64'(dif.d_dstM), 64'hF);
    chk("rr_valA", dif.d_valA, 64'h55);
    chk("rr_valB", dif.d_valB, 64'h0);

    // addq %rdx,%rsi: forwarding priority
    fetch(4'h6, 4'h2, 4'h6, 64'h0, 64'h2);
    tick();
    dif.e_dstE = 4'h2; dif.e_valE = 64'h7;
    dif.M_dstE = 4'h2; dif.M_valE = 64'h9;
    #1;
    chk("add_e_over_m", dif.d_valA, 64'h7);
    chk("add_srcB", 64'(dif.d_srcB), 64'h6);
    chk("add_dstE", 64'(dif.d_dstE), 64'h6);
    chk("add_valB", dif.d_valB, 64'h0);
    dif.e_dstE = 4'hF;
    #1;
    chk("add_m_valE", dif.d_valA, 64'h9);
    dif.M_dstE = 4'hF;
    dif.W_dstE = 4'h2; dif.W_valE = 64'hAB;
    dif.W_dstM = 4'h2; dif.W_valM = 64'hCD;
    #1;
    chk("add_wM_over_wE", dif.d_valA, 64'hCD);

    // popq %rax; this edge also writes regfile[2]=0xCD (M port wins)
    fetch(4'hB, 4'h0, 4'hF, 64'h0, 64'h2);
    tick();
    fwd_clear();
    dif.M_dstM = 4'h4; dif.m_valM = 64'h100;
    dif.M_dstE = 4'h4; dif.M_valE = 64'h200;
    #1;
    chk("pop_valB", dif.d_valB, 64'h100);
    chk("pop_valA", dif.d_valA, 64'h100);
    chk("pop_dstM", 64'(dif.d_dstM), 64'h0);
    chk("pop_dstE", 64'(dif.d_dstE), 64'h4);
    fwd_clear();

    // call: valA from valP, then stall and bubble
    fetch(4'h8, 4'hF, 4'hF, 64'h1234, 64'h2A);
    tick();
    chk("call_valA", dif.d_valA, 64'h2A);
    chk("call_srcB", 64'(dif.d_srcB), 64'h4);
    chk("call_dstE", 64'(dif.d_dstE), 64'h4);
    chk("call_srcA", 64'(dif.d_srcA), 64'hF);
    chk("call_valC", dif.D_valC, 64'h1234);
    fetch(4'h3, 4'hF, 4'h7, 64'h5, 64'hA);
    dif.D_stall = 1'b1;
    tick();
    chk("stall_icode", 64'(dif.D_icode), 64'h8);
    chk("stall_valA", dif.d_valA, 64'h2A);
    dif.D_stall = 1'b0;
    dif.D_bubble = 1'b1;
    tick();
    dif.D_bubble = 1'b0;
    chk("bub_icode", 64'(dif.D_icode), 64'h1);
    chk("bub_valC", dif.D_valC, 64'h0);
    chk("bub_valA", dif.d_valA, 64'h0);
    chk("bub_dstE", 64'(dif.d_dstE), 64'hF);

    // same-ID writeback on both ports while stall+bubble hold D
    fetch(4'h6, 4'h1, 4'h1, 64'h0, 64'h2);
    dif.W_dstE = 4'h5; dif.W_valE = 64'h1;
    dif.W_dstM = 4'h5; dif.W_valM = 64'h2;
    dif.D_stall = 1'b1;
    dif.D_bubble = 1'b1;
    tick();
    fwd_clear();
    dif.D_stall = 1'b0;
    dif.D_bubble = 1'b0;
    chk("hold_icode", 64'(dif.D_icode), 64'h1);
    fetch(4'h6, 4'h5, 4'h2, 64'h0, 64'h2);
    tick();
    chk("rf5_valM_wins", dif.d_valA, 64'h2);
    chk("rf2_valB", dif.d_valB, 64'hCD);

    // invalid icode: status passes through, no registers
    fetch(4'hC, 4'h1, 4'h2, 64'h0, 64'h2);
    dif.f_stat = 3'd3;
    tick();
    chk("inv_stat", 64'(dif.D_stat), 64'h3);
    chk("inv_srcA", 64'(dif.d_srcA), 64'hF);
    chk("inv_dstE", 64'(dif.d_dstE), 64'hF);
    chk("inv_valA", dif.d_valA, 64'h0);

    // reset mid-operation ignores a pending writeback and clears the regfile
    dif.W_dstE = 4'h1; dif.W_valE = 64'h77;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fwd_clear();
    chk("rst2_icode", 64'(dif.D_icode), 64'h1);
    fetch(4'h6, 4'h2, 4'h1, 64'h0, 64'h2);
    tick();
    chk("rst2_rf2", dif.d_valA, 64'h0);
    chk("rst2_rf1", dif.d_valB, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
